bit_reverse_buffer: RTL and testbench

BIT_REVERSE_BUFFER -- requirements
Module: bit_reverse_buffer

---
 rtl/bit_reverse_buffer.sv | 143 ++++++++++++++
 tb/tb_bit_reverse_buffer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_reverse_buffer.sv
// -----------------------------------------------------------------------------
// bit_reverse_buffer
//
// Collects one frame of N complex samples in natural order and replays it in
// bit-reversed order, which is the input ordering a radix-2 decimation-in-time
// butterfly stage expects. Samples are written to the buffer at the
// bit-reversed address and read back linearly. The reordering therefore costs
// nothing on the read side.
//
// The block alternates between two phases. It never fills and drains at the
// same time, so a frame occupies it for at least 2N cycles.
//
// Parameters
//   n         width of each real / imaginary word (passed through bit-exact)
//   N         samples per frame, power of two, N >= 2
//
// Ports
//   clk       rising-edge clock
//   reset     asynchronous, active-low reset
//   recv_val  upstream sample valid
//   recv_rdy  block can accept a sample (high throughout FILL)
//   recv_r/c  real / imaginary part of the incoming sample
//   send_val  outgoing sample valid (high throughout DRAIN)
//   send_rdy  downstream ready
//   send_r/c  real / imaginary part of the outgoing sample (zero outside DRAIN)
//   send_last high with the final sample of a frame
// -----------------------------------------------------------------------------
module bit_reverse_buffer #(
  parameter int n = 32,
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         recv_val,
  output logic         recv_rdy,
  input  logic [n-1:0] recv_r,
  input  logic [n-1:0] recv_c,
  output logic         send_val,
  input  logic         send_rdy,
  output logic [n-1:0] send_r,
  output logic [n-1:0] send_c,
  output logic         send_last
);

  localparam int K = $clog2(N);
  localparam logic [K-1:0] LAST_IDX = K'(N - 1);

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t state;
  state_t next_state;

  logic [K-1:0]   wr_idx;
  logic [K-1:0]   rd_idx;
  logic [2*n-1:0] mem [N];
  logic           accept;
  logic           xfer;

  // Mirror every index bit: bit i of the address comes from bit K-1-i of the
  // write counter.
  function automatic logic [K-1:0] bitrev(input logic [K-1:0] idx);
    logic [K-1:0] result;
    result = '0;
    for (int i = 0; i < K; i++) begin
      result[i] = idx[K-1-i];
    end
    return result;
  endfunction

  // State register. Reset is asynchronous, so the block returns to FILL (and
  // the outputs, which decode only the state, drop to their idle values)
  // without waiting for a clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FILL;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and output decode. The handshake outputs are pure functions of
  // the state, so recv_rdy never depends on send_rdy and send_val never
  // depends on recv_val. Data outputs are forced to zero outside DRAIN so the
  // buffer contents are visible only while a complete frame is being replayed.
  always_comb begin
    next_state = state;
    recv_rdy   = 1'b0;
    send_val   = 1'b0;
    send_r     = '0;
    send_c     = '0;
    send_last  = 1'b0;
    accept     = 1'b0;
    xfer       = 1'b0;
    case (state)
      FILL: begin
        recv_rdy = 1'b1;
        accept   = recv_val;
        if (recv_val && (wr_idx == LAST_IDX)) begin
          next_state = DRAIN;
        end
      end
      DRAIN: begin
        send_val         = 1'b1;
        {send_r, send_c} = mem[rd_idx];
        send_last        = (rd_idx == LAST_IDX);
        xfer             = send_rdy;
        if (send_rdy && (rd_idx == LAST_IDX)) begin
          next_state = FILL;
        end
      end
    endcase
  end

  // Write and read counters. Both are exactly K bits wide, so incrementing
  // past N-1 wraps to zero and leaves them ready for the next frame. A reset
  // mid-frame discards the partial frame by zeroing both counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_idx <= '0;
      rd_idx <= '0;
    end else begin
      if (accept) begin
        wr_idx <= wr_idx + 1'b1;
      end
      if (xfer) begin
        rd_idx <= rd_idx + 1'b1;
      end
    end
  end

  // Sample storage. The memory is deliberately left out of the reset. Stale
  // words are never observed, because DRAIN is entered only after all N
  // locations have been rewritten.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[bitrev(wr_idx)] <= {recv_r, recv_c};
    end
  end

endmodule

// File: tb/tb_bit_reverse_buffer.sv
// -----------------------------------------------------------------------------
// tb_bit_reverse_buffer
//
// Self-checking bench for bit_reverse_buffer (n = 32, N = 8). A reference
// model samples the handshakes on every falling edge. It collects accepted
// samples into a frame, and once the frame is complete it builds the expected
// output order by reversing each output position arithmetically. The model
// also tracks whether the block should be filling or draining, and checks the
// handshake and data outputs on every cycle against that expectation.
// -----------------------------------------------------------------------------
module tb_bit_reverse_buffer;

  localparam int W  = 32;
  localparam int NS = 8;
  localparam int KB = 3;

  logic         clk;
  logic         reset;
  logic         recv_val;
  logic         recv_rdy;
  logic [W-1:0] recv_r;
  logic [W-1:0] recv_c;
  logic         send_val;
  logic         send_rdy;
  logic [W-1:0] send_r;
  logic [W-1:0] send_c;
  logic         send_last;

  typedef struct packed {
    logic [W-1:0] r;
    logic [W-1:0] c;
    logic         last;
  } exp_t;

  exp_t         exp_q [$];
  exp_t         mon_e;
  logic [W-1:0] in_r [NS];
  logic [W-1:0] in_c [NS];
  int           in_cnt      = 0;
  logic         m_draining  = 1'b0;
  int           vectors     = 0;
  int           miscompares = 0;
  logic         rand_phase  = 1'b0;

  bit_reverse_buffer #(
    .n(W),
    .N(NS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .recv_val (recv_val),
    .recv_rdy (recv_rdy),
    .recv_r   (recv_r),
    .recv_c   (recv_c),
    .send_val (send_val),
    .send_rdy (send_rdy),
    .send_r   (send_r),
    .send_c   (send_c),
    .send_last(send_last)
  );

  // Free-running clock with a 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counts one comparison, and reports it if the observed value differs.
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Position j of a bit-reversed frame carries the input sample whose index
  // is j with its KB binary digits read backwards.
  function automatic int revIndex(input int j);
    int r;
    int v;
    r = 0;
    v = j;
    for (int b = 0; b < KB; b++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  // Reference model and per-cycle checker. Inputs change just after a rising
  // edge, so on the falling edge they already show the values the next rising
  // edge will act on. While reset is low the model checks the idle output
  // values and discards any partial frame.
  always @(negedge clk) begin
    if (!reset) begin
      checkOutput("rst_recv_rdy", recv_rdy, 1);
      checkOutput("rst_send_val", send_val, 0);
      checkOutput("rst_send_r", send_r, 0);
      checkOutput("rst_send_c", send_c, 0);
      checkOutput("rst_send_last", send_last, 0);
      in_cnt     = 0;
      m_draining = 1'b0;
      exp_q.delete();
    end else begin
      checkOutput("recv_rdy", recv_rdy, !m_draining);
      checkOutput("send_val", send_val, m_draining);
      if (m_draining) begin
        if (exp_q.size() == 0) begin
          checkOutput("exp_empty", 0, 1);
        end else begin
          mon_e = exp_q[0];
          checkOutput("send_r", send_r, mon_e.r);
          checkOutput("send_c", send_c, mon_e.c);
          checkOutput("send_last", send_last, mon_e.last);
          if (send_rdy) begin
            void'(exp_q.pop_front());
            if (mon_e.last) m_draining = 1'b0;
          end
        end
      end else begin
        checkOutput("idle_send_r", send_r, 0);
        checkOutput("idle_send_c", send_c, 0);
        checkOutput("idle_send_last", send_last, 0);
        if (recv_val) begin
          in_r[in_cnt] = recv_r;
          in_c[in_cnt] = recv_c;
          if (in_cnt == NS - 1) begin
            for (int j = 0; j < NS; j++) begin
              mon_e.r    = in_r[revIndex(j)];
              mon_e.c    = in_c[revIndex(j)];
              mon_e.last = (j == NS - 1);
              exp_q.push_back(mon_e);
            end
            in_cnt     = 0;
            m_draining = 1'b1;
          end else begin
            in_cnt++;
          end
        end
      end
    end
  end

  // Offers one sample and holds it until the block accepts it, then drops
  // recv_val just after that rising edge. The wait for the accept is bounded.
  task automatic applyStimulus(input logic [W-1:0] r, input logic [W-1:0] c);
    int t;
    t        = 0;
    recv_r   = r;
    recv_c   = c;
    recv_val = 1'b1;
    @(negedge clk);
    while (!recv_rdy && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) checkOutput("recv_timeout", 0, 1);
    @(posedge clk);
    #1;
    recv_val = 1'b0;
  endtask

  // Feeds real values base..base+7 with imaginary part ten times the real
  // part. When bubbles is set, recv_val goes low for one cycle between
  // samples.
  task automatic feedFrame(input logic [W-1:0] base, input bit bubbles);
    for (int i = 0; i < NS; i++) begin
      applyStimulus(base + W'(i), (base + W'(i)) * 10);
      if (bubbles) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  // Waits (bounded) until the model has seen every expected output leave the
  // block, then realigns to just after a rising edge.
  task automatic waitDrained();
    int t;
    t = 0;
    while ((m_draining || exp_q.size() != 0) && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) checkOutput("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  // Hard time limit so the bench always ends on its own.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence: directed scenarios first, then randomized frames.
  initial begin
    reset    = 1'b0;
    recv_val = 1'b0;
    recv_r   = '0;
    recv_c   = '0;
    send_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;

    $display("[TB] basic reorder");
    feedFrame(32'd0, 1'b0);
    waitDrained();

    $display("[TB] downstream stall");
    send_rdy = 1'b0;
    feedFrame(32'd0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    send_rdy = 1'b1;
    waitDrained();

    $display("[TB] input bubbles");
    feedFrame(32'd20, 1'b1);
    waitDrained();

    $display("[TB] back-to-back frames");
    feedFrame(32'd0, 1'b0);
    feedFrame(32'd100, 1'b0);
    waitDrained();

    $display("[TB] reset mid-fill");
    for (int i = 0; i < 3; i++) applyStimulus(32'hA0 + W'(i), 32'hB0 + W'(i));
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_fill_recv_rdy", recv_rdy, 1);
    checkOutput("async_fill_send_val", send_val, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    feedFrame(32'd200, 1'b0);
    waitDrained();

    $display("[TB] reset mid-drain");
    send_rdy = 1'b0;
    feedFrame(32'h55, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_drain_send_val", send_val, 0);
    checkOutput("async_drain_recv_rdy", recv_rdy, 1);
    checkOutput("async_drain_send_r", send_r, 0);
    checkOutput("async_drain_send_c", send_c, 0);
    checkOutput("async_drain_send_last", send_last, 0);
    @(posedge clk);
    #1;
    reset    = 1'b1;
    send_rdy = 1'b1;
    feedFrame(32'd300, 1'b0);
    waitDrained();

    $display("[TB] extreme values");
    for (int i = 0; i < NS; i++) begin
      if (i % 2 == 0) applyStimulus(32'h7FFF_FFFF, 32'h8000_0000);
      else            applyStimulus(32'h8000_0000, 32'h7FFF_FFFF);
    end
    waitDrained();

    $display("[TB] randomized frames");
    rand_phase = 1'b1;
    fork
      begin
        for (int f = 0; f < 6; f++) begin
          for (int i = 0; i < NS; i++) begin
            applyStimulus($urandom, $urandom);
            if ($urandom_range(0, 2) == 0) begin
              @(posedge clk);
              #1;
            end
          end
        end
        waitDrained();
        rand_phase = 1'b0;
      end
      begin
        while (rand_phase) begin
          @(posedge clk);
          #1;
          send_rdy = ($urandom_range(0, 3) != 0);
        end
        send_rdy = 1'b1;
      end
    join

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
